// File: rtl/game_controller.sv
`default_nettype none
// ============================================================================
// game_controller : Pong match sequencer (match FSM, scores, serve control)
// Revision 1.0
// ============================================================================
module game_controller #(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 120,
  parameter int POINT_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       wrap_sel,
  input  logic       frame_tick,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       game_on,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic       wrap_mode,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic [1:0] winner,
  output logic [2:0] state
);

  localparam int CNT_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] c_serve_cnt = CNT_W'(SERVE_FRAMES);
  localparam logic [CNT_W-1:0] c_point_cnt = CNT_W'(POINT_FRAMES);
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
  localparam logic [3:0]       c_win       = 4'(WIN_SCORE);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       score_left_q, score_left_d;
  logic [3:0]       score_right_q, score_right_d;
  logic [1:0]       winner_q, winner_d;
  logic             game_on_q, game_on_d;
  logic             ball_reset_q, ball_reset_d;
  logic             serve_dir_q, serve_dir_d;
  logic             wrap_mode_q, wrap_mode_d;
  logic             paused_q, paused_d;
  logic             start_q, pause_q;
  logic             start_edge, pause_edge;

  assign start_edge = start & ~start_q;
  assign pause_edge = pause & ~pause_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    score_left_d  = score_left_q;
    score_right_d = score_right_q;
    winner_d      = winner_q;
    serve_dir_d   = serve_dir_q;
    wrap_mode_d   = wrap_mode_q;
    paused_d      = paused_q;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_edge) begin
          score_left_d  = 4'd0;
          score_right_d = 4'd0;
          winner_d      = 2'b00;
          wrap_mode_d   = wrap_sel;
          serve_dir_d   = 1'b0;
          cnt_d         = c_serve_cnt;
          state_d       = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (frame_tick) begin
          if (cnt_q == c_cnt_one) state_d = ST_PLAY;
          else                    cnt_d   = cnt_q - c_cnt_one;
        end
      end
      ST_PLAY: begin
        // A simultaneous double miss is a void point: nobody scores.
        if (!paused_q && miss_left && miss_right) begin
          cnt_d    = c_point_cnt;
          state_d  = ST_POINT;
          paused_d = 1'b0;
        end else if (!paused_q && miss_left) begin
          score_right_d = (score_right_q == 4'hF) ? 4'hF : score_right_q + 4'd1;
          serve_dir_d   = 1'b0;
          paused_d      = 1'b0;
          if (score_right_d == c_win) begin
            winner_d = 2'b10;
            state_d  = ST_OVER;
          end else begin
            cnt_d   = c_point_cnt;
            state_d = ST_POINT;
          end
        end else if (!paused_q && miss_right) begin
          score_left_d = (score_left_q == 4'hF) ? 4'hF : score_left_q + 4'd1;
          serve_dir_d  = 1'b1;
          paused_d     = 1'b0;
          if (score_left_d == c_win) begin
            winner_d = 2'b01;
            state_d  = ST_OVER;
          end else begin
            cnt_d   = c_point_cnt;
            state_d = ST_POINT;
          end
        end else if (pause_edge) begin
          paused_d = ~paused_q;
        end
      end
      ST_POINT: begin
        if (frame_tick) begin
          if (cnt_q == c_cnt_one) begin
            cnt_d   = c_serve_cnt;
            state_d = ST_SERVE;
          end else begin
            cnt_d = cnt_q - c_cnt_one;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs follow the next state so they line up with the state register.
    game_on_d    = (state_d == ST_SERVE) | ((state_d == ST_PLAY) & ~paused_d);
    ball_reset_d = (state_d != ST_PLAY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      score_left_q  <= 4'd0;
      score_right_q <= 4'd0;
      winner_q      <= 2'b00;
      game_on_q     <= 1'b0;
      ball_reset_q  <= 1'b1;
      serve_dir_q   <= 1'b0;
      wrap_mode_q   <= 1'b0;
      paused_q      <= 1'b0;
      start_q       <= 1'b1;
      pause_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      score_left_q  <= score_left_d;
      score_right_q <= score_right_d;
      winner_q      <= winner_d;
      game_on_q     <= game_on_d;
      ball_reset_q  <= ball_reset_d;
      serve_dir_q   <= serve_dir_d;
      wrap_mode_q   <= wrap_mode_d;
      paused_q      <= paused_d;
      start_q       <= start;
      pause_q       <= pause;
    end
  end

  assign game_on     = game_on_q;
  assign ball_reset  = ball_reset_q;
  assign serve_dir   = serve_dir_q;
  assign wrap_mode   = wrap_mode_q;
  assign score_left  = score_left_q;
  assign score_right = score_right_q;
  assign winner      = winner_q;
  assign state       = state_q;

endmodule
`default_nettype wire

// File: doc/game_controller.md
Name: game_controller

Overview:
- Top-level Pong match sequencer: owns the match state machine and both scores.
- Drives the paddle block's game_on and wrap_mode inputs, plus the ball block's ball_reset and serve_dir.
- Consumes miss pulses from the ball logic and a one-cycle frame strobe from the VGA timing generator.
- Sits between the user controls (start/pause buttons, wrap switch) and the paddle/ball datapaths.

Parameters:
- WIN_SCORE, 7, score that ends the match (1..15).
- SERVE_FRAMES, 120, frame_tick count spent in SERVE before the ball is released (>=1).
- POINT_FRAMES, 60, frame_tick count of post-point freeze (>=1).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  start button level, debounced upstream
- pause  in  1  pause button level, debounced upstream
- wrap_sel  in  1  wrap switch, sampled at match start
- frame_tick  in  1  one-cycle strobe, once per video frame
- miss_left  in  1  one-cycle pulse: ball passed the left paddle
- miss_right  in  1  one-cycle pulse: ball passed the right paddle
- game_on  out  1  paddles enabled
- ball_reset  out  1  hold ball at centre
- serve_dir  out  1  0 = serve toward left player, 1 = toward right
- wrap_mode  out  1  latched wrap_sel for the paddles
- score_left  out  4  left player score
- score_right  out  4  right player score
- winner  out  2  00 none, 01 left, 10 right
- state  out  3  IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4

Behaviour:
- All outputs registered. An input event at edge n is visible on the outputs after edge n+1.
- Reset values:
  - state=IDLE
  - scores=0, winner=00
  - game_on=0, ball_reset=1, serve_dir=0, wrap_mode=0
  - paused=0, frame counter=0
  - start_q=1 and pause_q=1, so a button held through reset is not an edge.
- Reset wins over every other input in the same cycle, including mid-PLAY.
- Edge detection: start_edge = start & ~start_q; pause_edge = pause & ~pause_q. Level-held buttons act once.
- IDLE: game_on=0, ball_reset=1. On start_edge:
  - scores:=0, winner:=00
  - wrap_mode:=wrap_sel, serve_dir:=0
  - cnt:=SERVE_FRAMES, go to SERVE.
- SERVE: game_on=1, ball_reset=1.
  - On frame_tick: if cnt==1 go to PLAY, else cnt--.
  - SERVE therefore lasts exactly SERVE_FRAMES ticks.
- PLAY: ball_reset=0, game_on=~paused.
  - pause_edge toggles paused.
  - While paused, misses are ignored and ball_reset stays 0; the ball block freezes on game_on=0.
- PLAY miss handling (not paused):
  - miss_left alone: score_right++, serve_dir:=0.
  - miss_right alone: score_left++, serve_dir:=1.
  - Both in the same cycle: no score change, serve_dir unchanged, go to POINT.
  - After scoring: if the new score == WIN_SCORE, go to OVER and set winner to the scorer. Otherwise cnt:=POINT_FRAMES and go to POINT.
  - paused:=0 on leaving PLAY.
- Scores saturate at 15 and never wrap. WIN_SCORE<=15 guarantees OVER is reached first.
- POINT: game_on=0, ball_reset=1. On frame_tick: if cnt==1, cnt:=SERVE_FRAMES and go to SERVE; else cnt--.
- OVER: game_on=0, ball_reset=1. Scores and winner hold. start_edge behaves as in IDLE: clears scores/winner, relatches wrap_mode, goes to SERVE.
- Ignored inputs:
  - miss pulses outside PLAY.
  - pause_edge outside PLAY.
  - start_edge in SERVE, PLAY and POINT.
- wrap_mode changes only on a start_edge accepted in IDLE/OVER. Toggling wrap_sel mid-match has no effect.
- frame_tick in the same cycle as the state-entry edge does not count toward the new state's cnt.
- Illegal state encodings (5-7) return to IDLE on the next clock.

Test Plan:
Use WIN_SCORE=3, SERVE_FRAMES=2, POINT_FRAMES=2.
1. Reset with start held high, then keep start high 10 cycles -> state=0, game_on=0, ball_reset=1. Release start, pulse start -> state=1 next cycle; after 2 frame_ticks -> state=2, ball_reset=0, game_on=1.
2. In PLAY, pulse miss_right -> next cycle score_left=1, serve_dir=1, state=3, game_on=0. After 2 frame_ticks -> state=1. After 2 more -> state=2.
3. Right player scores 3 times via miss_left -> score_right=3, winner=10, state=4. Further miss pulses leave scores unchanged. start pulse -> scores 0, winner 00, state=1.
4. In PLAY, pulse pause -> game_on=0. Pulse miss_left while paused -> scores unchanged. Pulse pause again -> game_on=1.
5. In PLAY, assert miss_left and miss_right in the same cycle -> scores unchanged, serve_dir unchanged, state=3.
6. Start with wrap_sel=1 -> wrap_mode=1. Flip wrap_sel to 0 mid-PLAY -> wrap_mode stays 1. Assert reset mid-POINT -> all outputs return to reset values on the next edge.
